// File: rtl/sd_data_tx_pkg.sv
// Shared types and constants for the SD DAT0 block transmitter.
// SD_TX_BUSY_WAIT_EN adds the card-busy WAIT state.
package sd_data_tx_pkg;

    localparam int unsigned START_BITS = 1;
    localparam int unsigned CRC_BITS   = 16;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned CRC_CNT_W  = $clog2(CRC_BITS);

    localparam logic [15:0] CRC16_POLY = 16'h1021;

`ifdef SD_TX_BUSY_WAIT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP,
        ST_WAIT
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP
    } tx_state_t;
`endif

    // One serial step of the CRC16 LFSR.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_data_tx_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1) accumulator with synchronous clear.
module sd_crc16_sync
    import sd_data_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_data_tx.sv
// SD DAT0 single-line block transmitter: start bit, payload, CRC16, end bit.
// SD_TX_BUSY_WAIT_EN enables waiting for card busy release after the end bit.
module sd_data_tx
    import sd_data_tx_pkg::*;
#(
    parameter int unsigned BLK_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] blk_len,
    input  logic             bit_en,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sd_dat_o,
    output logic             sd_dat_oe,
    input  logic             sd_dat_i,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [15:0]      crc_o
);

    tx_state_t              state, state_n;
    logic [BLK_W-1:0]       len_q, len_n;
    logic [BLK_W-1:0]       byte_cnt, byte_cnt_n;
    logic [BLK_W-1:0]       acc_cnt, acc_cnt_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [7:0]             shift_q, shift_n;
    logic [7:0]             hold_q, hold_n;
    logic                   hold_full, hold_full_n;
    logic [15:0]            cshift, cshift_n;
    logic [CRC_CNT_W-1:0]   crc_cnt, crc_cnt_n;
    logic                   dat_n, oe_n, ready_n, busy_n, done_n, underrun_n;
    logic [15:0]            crc_o_n;

    logic                   crc_clr, crc_en, crc_bit;
    logic [15:0]            crc;
    logic                   hs, byte_avail, take;
    logic [7:0]             byte_src;

`ifndef SD_TX_BUSY_WAIT_EN
    logic unused_sd_dat_i;
    assign unused_sd_dat_i = sd_dat_i;
`endif

    sd_crc16_sync u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    // Next-state and output logic; a byte arriving this cycle may bypass the hold register.
    always_comb begin
        state_n     = state;
        len_n       = len_q;
        byte_cnt_n  = byte_cnt;
        acc_cnt_n   = acc_cnt;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_q;
        hold_n      = hold_q;
        hold_full_n = hold_full;
        cshift_n    = cshift;
        crc_cnt_n   = crc_cnt;
        dat_n       = sd_dat_o;
        oe_n        = sd_dat_oe;
        done_n      = 1'b0;
        underrun_n  = underrun;
        crc_o_n     = crc_o;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = 1'b0;
        take        = 1'b0;

        hs         = data_valid && data_ready;
        byte_avail = hold_full || hs;
        byte_src   = hold_full ? hold_q : data_in;

        if (hs) begin
            acc_cnt_n = acc_cnt + BLK_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_START;
                    len_n      = blk_len;
                    byte_cnt_n = '0;
                    acc_cnt_n  = '0;
                    bit_cnt_n  = '0;
                    crc_cnt_n  = '0;
                    crc_clr    = 1'b1;
                    underrun_n = 1'b0;
                    dat_n      = 1'b0;
                    oe_n       = 1'b1;
                end
            end
            ST_START: begin
                if (bit_en) begin
                    if (len_q == '0) begin
                        state_n   = ST_CRC;
                        dat_n     = crc[15];
                        cshift_n  = {crc[14:0], 1'b0};
                        crc_cnt_n = '0;
                    end else if (byte_avail) begin
                        take = 1'b1;
                    end else begin
                        underrun_n = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_en) begin
                    if (bit_cnt != 3'd7) begin
                        dat_n     = shift_q[6];
                        shift_n   = {shift_q[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 3'd1;
                        crc_en    = 1'b1;
                        crc_bit   = shift_q[6];
                    end else if (byte_cnt == len_q) begin
                        state_n   = ST_CRC;
                        dat_n     = crc[15];
                        cshift_n  = {crc[14:0], 1'b0};
                        crc_cnt_n = '0;
                    end else if (byte_avail) begin
                        take = 1'b1;
                    end else begin
                        underrun_n = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (bit_en) begin
                    if (crc_cnt == CRC_CNT_W'(CRC_BITS - 1)) begin
                        state_n = ST_STOP;
                        dat_n   = 1'b1;
                    end else begin
                        dat_n     = cshift[15];
                        cshift_n  = {cshift[14:0], 1'b0};
                        crc_cnt_n = crc_cnt + CRC_CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_en) begin
                    oe_n    = 1'b0;
                    dat_n   = 1'b1;
                    crc_o_n = crc;
`ifdef SD_TX_BUSY_WAIT_EN
                    state_n = ST_WAIT;
`else
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
`endif
                end
            end
`ifdef SD_TX_BUSY_WAIT_EN
            ST_WAIT: begin
                if (bit_en && sd_dat_i) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Move the next byte onto the line, MSB first.
        if (take) begin
            state_n    = ST_DATA;
            shift_n    = byte_src;
            dat_n      = byte_src[7];
            crc_en     = 1'b1;
            crc_bit    = byte_src[7];
            bit_cnt_n  = '0;
            byte_cnt_n = byte_cnt + BLK_W'(1);
        end

        if (take && hold_full) begin
            hold_full_n = 1'b0;
        end
        if (hs && !take) begin
            hold_n      = data_in;
            hold_full_n = 1'b1;
        end

        busy_n  = (state_n != ST_IDLE);
        ready_n = (state_n != ST_IDLE) && !hold_full_n && (acc_cnt_n < len_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            byte_cnt   <= '0;
            acc_cnt    <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_full  <= 1'b0;
            cshift     <= '0;
            crc_cnt    <= '0;
            sd_dat_o   <= 1'b1;
            sd_dat_oe  <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            crc_o      <= 16'h0000;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            byte_cnt   <= byte_cnt_n;
            acc_cnt    <= acc_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_q    <= shift_n;
            hold_q     <= hold_n;
            hold_full  <= hold_full_n;
            cshift     <= cshift_n;
            crc_cnt    <= crc_cnt_n;
            sd_dat_o   <= dat_n;
            sd_dat_oe  <= oe_n;
            data_ready <= ready_n;
            busy       <= busy_n;
            done       <= done_n;
            underrun   <= underrun_n;
            crc_o      <= crc_o_n;
        end
    end

endmodule

// File: tb/tb_sd_data_tx.sv
// Scoreboard bench for sd_data_tx: expected line bits and CRC per frame, checked by a negedge monitor.
module tb_sd_data_tx;

    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst, start, bit_en, data_valid, sd_dat_i;
    logic [BW-1:0] blk_len;
    logic [7:0]    data_in;
    logic          data_ready, sd_dat_o, sd_dat_oe, busy, done, underrun;
    logic [15:0]   crc_o;

    always #5 clk = ~clk;

    sd_data_tx #(.BLK_W(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .blk_len    (blk_len),
        .bit_en     (bit_en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .sd_dat_o   (sd_dat_o),
        .sd_dat_oe  (sd_dat_oe),
        .sd_dat_i   (sd_dat_i),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .crc_o      (crc_o)
    );

    int n_vec = 0, n_bad = 0;

    bit          exp_bits[$];
    logic [15:0] exp_crc[$];
    int          exp_nbits[$];
    logic [7:0]  tx_q[$];

    int stall_byte = -1, stall_left = 0, en_mode = 0, acc_drv = 0;
    int frame_pos = 0, acc_seen = 0, frames_done = 0, cur_len = 0;
    bit stalled = 0, ready_seen = 0, hs_drv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC16 of a byte list, MSB-first serial, init 0.
    function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
        logic [15:0] c;
        logic [7:0]  v;
        logic        fb;
        c = 16'h0000;
        foreach (b[k]) begin
            v = b[k];
            for (int i = 7; i >= 0; i--) begin
                fb = v[i] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    // Byte source and bit strobe driver.
    always @(negedge clk) hs_drv = data_valid && data_ready;

    initial begin
        data_valid = 1'b0;
        data_in    = 8'h00;
        bit_en     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_drv && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                acc_drv++;
            end
            if (acc_drv == stall_byte && stall_left > 0) begin
                data_valid = 1'b0;
                stall_left--;
            end else if (tx_q.size() > 0) begin
                data_valid = 1'b1;
                data_in    = tx_q[0];
            end else begin
                data_valid = 1'b0;
            end
            bit_en = (en_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: consumes one expected bit per advancing bit_en cycle; models byte-starved stalls.
    always @(negedge clk) begin
        int  p, b;
        bit  need, avail;
        if (!rst) begin
            if (data_ready) ready_seen = 1'b1;
            if (done) begin
                frames_done++;
                if (exp_crc.size() > 0) begin
                    check("crc_o", 32'(crc_o), 32'(exp_crc.pop_front()));
                    check("frame_bits", 32'(frame_pos), 32'(exp_nbits.pop_front()));
                end else begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end
                check("underrun", 32'(underrun), 32'(stalled));
                check("busy_at_done", 32'(busy), 32'd0);
                if (cur_len == 0) check("ready_len0", 32'(ready_seen), 32'd0);
            end
            if (sd_dat_oe && bit_en) begin
                p     = frame_pos;
                b     = p / 8;
                need  = (p < 8 * cur_len) && (p % 8 == 0);
                avail = (acc_seen > b) || (acc_seen == b && data_valid && data_ready);
                if (need && !avail) begin
                    stalled = 1'b1;
                    if (exp_bits.size() > 0) check("stall_hold", 32'(sd_dat_o), 32'(exp_bits[0]));
                end else if (exp_bits.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL extra_bit: got %0d expected none", sd_dat_o);
                end else begin
                    check("line_bit", 32'(sd_dat_o), 32'(exp_bits.pop_front()));
                    frame_pos++;
                end
            end
            if (data_valid && data_ready) acc_seen++;
        end
    end

    task automatic prep_frame(input int len, input int kind);
        logic [7:0]  b[$];
        logic [15:0] c;
        for (int i = 0; i < len; i++)
            b.push_back(kind == 0 ? 8'hFF : (kind == 1 ? 8'h80 : 8'($urandom)));
        c = crc_model(b);
        exp_bits.push_back(1'b0);
        foreach (b[k]) for (int i = 7; i >= 0; i--) exp_bits.push_back(b[k][i]);
        for (int i = 15; i >= 0; i--) exp_bits.push_back(c[i]);
        exp_bits.push_back(1'b1);
        exp_crc.push_back(c);
        exp_nbits.push_back(8 * len + 18);
        cur_len = len; frame_pos = 0; acc_seen = 0; stalled = 0; ready_seen = 0; acc_drv = 0;
        foreach (b[k]) tx_q.push_back(b[k]);
        @(posedge clk); #1;
        start   = 1'b1;
        blk_len = BW'(len);
        @(posedge clk); #1;
        start   = 1'b0;
        blk_len = BW'($urandom);
    endtask

    task automatic clear_model();
        exp_bits.delete(); exp_crc.delete(); exp_nbits.delete(); tx_q.delete();
        acc_drv = 0; stall_left = 0; stall_byte = -1; frame_pos = 0; acc_seen = 0;
    endtask

    task automatic wait_done(input bit poke);
        int fd, n;
        fd = frames_done;
        n  = 0;
        while (frames_done == fd && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 30 && busy && frames_done == fd) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
        end
        if (frames_done == fd) begin
            n_vec++; n_bad++;
            $display("FAIL frame_timeout: got no done expected done within 20000 cycles");
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            clear_model();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; blk_len = '0; sd_dat_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dat_o", 32'(sd_dat_o), 32'd1);
        check("rst_oe", 32'(sd_dat_oe), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_crc_o", 32'(crc_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        en_mode = 0;
        prep_frame(512, 0); wait_done(1'b0);
        check("crc_512_ff", 32'(crc_o), 32'h7FA1);

        prep_frame(1, 1); wait_done(1'b0);
        prep_frame(0, 2); wait_done(1'b0);
        check("crc_len0", 32'(crc_o), 32'h0000);

        stall_byte = 3; stall_left = 20;
        prep_frame(8, 2); wait_done(1'b0);
        check("underrun_sticky", 32'(underrun), 32'd1);
        stall_byte = -1;

        en_mode = 1;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(0, 20);
            prep_frame(n, 2);
            wait_done(n >= 4);
        end
        prep_frame(0, 2); wait_done(1'b0);

        en_mode = 0;
        prep_frame(32, 2);
        n = 0;
        while (frame_pos < 101 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_bit100", 32'(frame_pos >= 101), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_oe", 32'(sd_dat_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(data_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        prep_frame(5, 2); wait_done(1'b0);

`ifdef SD_TX_BUSY_WAIT_EN
        sd_dat_i = 1'b0;
        prep_frame(2, 2);
        n = 0;
        while (frame_pos < 34 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("wait_no_done", 32'(done), 32'd0);
        end
        sd_dat_i = 1'b1;
        wait_done(1'b0);
        @(posedge clk); #1;
        check("done_single", 32'(done), 32'd0);
`endif

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
